trigger_capture: RTL
====================

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 12, sample width matching the FIFO data width.
REQ-002 SHALL have parameter LEN_SIZE, default 10, capture-length counter width.
REQ-003 SHALL have parameter TMO_SIZE, default 16, auto-trigger timeout counter width.
REQ-004 SHALL have port clk_i  input  1  single clock; the FIFO read clock.
REQ-005 SHALL have port rst_i  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port fifo_data_i  input  DATA_SIZE  FIFO read data, first-word fall-through (valid while !fifo_empty_i).
REQ-007 SHALL have port fifo_empty_i  input  1  FIFO empty flag.
REQ-008 SHALL have port fifo_inc_o  output  1  FIFO pop; one word consumed per cycle high.
REQ-009 SHALL have port arm_i  input  1  single-cycle arm request.
REQ-010 SHALL have port abort_i  input  1  return to IDLE; priority over all other inputs except reset.
REQ-011 SHALL have port auto_i  input  1  enable timeout-forced trigger.
REQ-012 SHALL have port rising_i  input  1  1 = rising-edge trigger, 0 = falling-edge trigger.
REQ-013 SHALL have port level_i  input  DATA_SIZE  unsigned trigger level.
REQ-014 SHALL have port len_i  input  LEN_SIZE  post-trigger sample count; 0 treated as 1.
REQ-015 SHALL have port timeout_i  input  TMO_SIZE  auto-trigger timeout in clk_i cycles.
REQ-016 SHALL have port sample_o  output  DATA_SIZE  registered captured sample.
REQ-017 SHALL have port sample_valid_o  output  1  sample_o valid.
REQ-018 SHALL have port sample_ready_i  input  1  downstream accepts when valid&&ready.
REQ-019 SHALL have port trig_o  output  1  one-cycle pulse on trigger.
REQ-020 SHALL have port forced_o  output  1  last trigger was timeout-forced; held until next arm.
REQ-021 SHALL have port busy_o  output  1  high in ARMED or CAPTURE.
REQ-022 SHALL have port done_o  output  1  high in DONE.

Function
REQ-023 SHALL implement states IDLE, ARMED, CAPTURE, DONE.
REQ-024 SHALL, in IDLE and DONE, assert fifo_inc_o = !fifo_empty_i (discard, keep FIFO drained).
REQ-025 SHALL, on arm_i in IDLE or DONE, latch rising_i, level_i, len_i, auto_i, timeout_i, clear prev-valid, timeout count and forced_o, and enter ARMED next cycle; arm_i in ARMED/CAPTURE ignored.
REQ-026 SHALL, in ARMED, assert fifo_inc_o = !fifo_empty_i; each popped word updates prev sample and sets prev-valid.
REQ-027 SHALL detect rising trigger when prev-valid && prev < level && cur >= level; falling when prev-valid && prev > level && cur <= level; unsigned compare; first popped word after arm never triggers.
REQ-028 SHALL count ARMED cycles when auto_i latched; when count reaches timeout_i, the next popped word forces a trigger and sets forced_o; timeout_i = 0 forces on the first popped word.
REQ-029 SHALL, on the trigger pop cycle, load the triggering word into sample_o, set sample_valid_o, pulse trig_o, set captured count = 1, enter CAPTURE next cycle.
REQ-030 SHALL, in CAPTURE, assert fifo_inc_o = !fifo_empty_i && (!sample_valid_o || sample_ready_i) && count < len; each pop loads sample_o, holds valid, increments count.
REQ-031 SHALL clear sample_valid_o on acceptance when no new word loads that cycle; sample_o SHALL be stable while valid && !ready.
REQ-032 SHALL enter DONE the cycle after the len-th sample is accepted; exactly len samples emitted per capture, in FIFO order.
REQ-033 SHALL, on abort_i in any state, enter IDLE next cycle, clear sample_valid_o, not pop that cycle.
REQ-034 SHALL never pop while fifo_empty_i is high; downstream stall in CAPTURE back-pressures the FIFO only.

Reset
REQ-035 SHALL, when rst_i low at clk_i edge, enter IDLE; sample_o = 0, sample_valid_o = 0, trig_o = 0, forced_o = 0, busy_o = 0, done_o = 0, counters and prev-valid cleared; fifo_inc_o = 0 during reset.
REQ-036 SHALL, on reset mid-capture, discard the in-flight sample without emitting it.

Verification
REQ-037 Rising: level=100, len=3, stream 50,90,110,120,130,140, ready=1 -> trig_o at 110; outputs 110,120,130; DONE; 140 not emitted.
REQ-038 Falling: rising=0, level=100, stream 120,100,80 -> trigger on 100 (prev 120 > 100, cur <= 100), forced_o=0.
REQ-039 Auto: auto=1, timeout=5, flat stream 10 -> forced trigger on first pop after 5 ARMED cycles, forced_o=1.
REQ-040 Back-pressure: ready=0 for 4 cycles mid-capture -> sample_o stable, fifo_inc_o=0, no sample lost or duplicated.
REQ-041 Abort in CAPTURE after 1 of len=4 -> IDLE next cycle, valid=0, FIFO drained; re-arm captures fresh.
REQ-042 len=0, first word already above level -> no trigger on first word; len treated as 1 (one sample emitted).

Source files
------------

// File: rtl/trigger_capture.sv
// Edge/level trigger on a first-word-fall-through FIFO stream; captures len samples after the trigger into a registered valid/ready output.
// Output sample registered one cycle after its pop; a downstream stall holds the sample and pauses FIFO pops (capture only).
module trigger_capture #(
    parameter int DATA_SIZE = 12,
    parameter int LEN_SIZE  = 10,
    parameter int TMO_SIZE  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_SIZE-1:0] fifo_data_i,
    input  logic                 fifo_empty_i,
    output logic                 fifo_inc_o,
    input  logic                 arm_i,
    input  logic                 abort_i,
    input  logic                 auto_i,
    input  logic                 rising_i,
    input  logic [DATA_SIZE-1:0] level_i,
    input  logic [LEN_SIZE-1:0]  len_i,
    input  logic [TMO_SIZE-1:0]  timeout_i,
    output logic [DATA_SIZE-1:0] sample_o,
    output logic                 sample_valid_o,
    input  logic                 sample_ready_i,
    output logic                 trig_o,
    output logic                 forced_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]           state;
    logic                 rising_q;
    logic                 auto_q;
    logic [DATA_SIZE-1:0] level_q;
    logic [LEN_SIZE-1:0]  len_q;
    logic [TMO_SIZE-1:0]  timeout_q;
    logic [TMO_SIZE-1:0]  tmo_cnt;
    logic [DATA_SIZE-1:0] prev;
    logic                 prev_vld;
    logic [LEN_SIZE-1:0]  cnt;

    logic pop;
    logic hit_rise;
    logic hit_fall;
    logic natural_hit;
    logic tmo_reached;

    assign hit_rise    = prev_vld && (prev < level_q) && (fifo_data_i >= level_q);
    assign hit_fall    = prev_vld && (prev > level_q) && (fifo_data_i <= level_q);
    assign natural_hit = rising_q ? hit_rise : hit_fall;
    assign tmo_reached = auto_q && (tmo_cnt >= timeout_q);

    always_comb begin
        pop = 1'b0;
        if (rst_i && !abort_i) begin
            case (state)
                S_CAPTURE: pop = !fifo_empty_i && (!sample_valid_o || sample_ready_i) && (cnt < len_q);
                default:   pop = !fifo_empty_i;
            endcase
        end
    end

    assign fifo_inc_o = pop;
    assign busy_o     = (state == S_ARMED) || (state == S_CAPTURE);
    assign done_o     = (state == S_DONE);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state          <= S_IDLE;
            rising_q       <= 1'b0;
            auto_q         <= 1'b0;
            level_q        <= '0;
            len_q          <= '0;
            timeout_q      <= '0;
            tmo_cnt        <= '0;
            prev           <= '0;
            prev_vld       <= 1'b0;
            cnt            <= '0;
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
            trig_o         <= 1'b0;
            forced_o       <= 1'b0;
        end else begin
            trig_o <= 1'b0;
            if (abort_i) begin
                state          <= S_IDLE;
                sample_valid_o <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (arm_i) begin
                            rising_q  <= rising_i;
                            auto_q    <= auto_i;
                            level_q   <= level_i;
                            len_q     <= (len_i == '0) ? LEN_SIZE'(1) : len_i;
                            timeout_q <= timeout_i;
                            tmo_cnt   <= '0;
                            prev_vld  <= 1'b0;
                            forced_o  <= 1'b0;
                            state     <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (auto_q && (tmo_cnt != '1)) begin
                            tmo_cnt <= tmo_cnt + TMO_SIZE'(1);
                        end
                        if (pop) begin
                            prev     <= fifo_data_i;
                            prev_vld <= 1'b1;
                            // A genuine crossing wins over the timeout, so forced_o only marks true auto-triggers.
                            if (natural_hit || tmo_reached) begin
                                sample_o       <= fifo_data_i;
                                sample_valid_o <= 1'b1;
                                trig_o         <= 1'b1;
                                forced_o       <= !natural_hit;
                                cnt            <= LEN_SIZE'(1);
                                state          <= S_CAPTURE;
                            end
                        end
                    end
                    S_CAPTURE: begin
                        if (pop) begin
                            sample_o       <= fifo_data_i;
                            sample_valid_o <= 1'b1;
                            cnt            <= cnt + LEN_SIZE'(1);
                        end else if (sample_valid_o && sample_ready_i) begin
                            sample_valid_o <= 1'b0;
                            if (cnt == len_q) begin
                                state <= S_DONE;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
